// File: rtl/pcs_scrambler_stream_if.sv
// pcs_scrambler_stream_if: stream bundle for the PCS scrambler.
// Carries the upstream (s_*) and downstream (m_*) valid/ready channels.
// The slave modport is the block's view. The master modport is the
// surrounding logic's view: it drives the input word and accepts the output.

interface pcs_scrambler_stream_if #(
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WIDTH  = 2
);

   // upstream channel into the scrambler
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic [HDR_WIDTH-1:0]  s_hdr;

   // downstream channel out of the scrambler
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [HDR_WIDTH-1:0]  m_hdr;

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_hdr,
      input  m_ready,
      output s_ready,
      output m_valid,
      output m_data,
      output m_hdr
   );

   modport master (
      output s_valid,
      output s_data,
      output s_hdr,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  m_data,
      input  m_hdr
   );

endinterface

// File: rtl/pcs_scrambler_stream.sv
// pcs_scrambler_stream: streaming self-synchronous scrambler/descrambler for
// g(x) = 1 + x^39 + x^58, as used by the 40G/100G PCS (64b/66b payload).
//
// - DESCRAMBLE = 0: multiplicative scrambler (line bits fed back).
// - DESCRAMBLE = 1: descrambler (received line bits fed forward).
// In both modes the 58-bit state holds line-side (scrambled) bits, with
// state[0] the most recent one. Bit 0 of a word is the first on the line.
//
// The header sideband travels with its word through the same output
// register and never touches the LFSR.
//
// The state advances only when a word is accepted. Idle and stalled
// cycles leave it untouched.
//
// Optional feature macro: PCS_SCR_SEED_LOAD_EN
//   Adds seed_load / seed_value for a runtime reseed of the state.
//   A load wins over the state update of a word accepted in the same
//   cycle. That word is still processed with the old state.

module pcs_scrambler_stream #(
   parameter int          DATA_WIDTH = 64,
   parameter int          HDR_WIDTH  = 2,
   parameter int          DESCRAMBLE = 0,
   parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
   input  logic                  CLK,
   input  logic                  rst_n,
`ifdef PCS_SCR_SEED_LOAD_EN
   input  logic                  seed_load,
   input  logic [57:0]           seed_value,
`endif
   pcs_scrambler_stream_if.slave bus
);

   // polynomial geometry
   localparam int LFSR_LEN = 58;
   localparam int TAP_NEAR = 39;
   localparam int TAP_FAR  = 58;

   // history vector: state bits (oldest at index 0) followed by this word's line bits
   localparam int HIST_W   = LFSR_LEN + DATA_WIDTH;

   // ------------------------------------------------------------------
   // Feedback term for the line bit sitting at history position pos:
   // XOR of the bits 39 and 58 positions earlier on the line.
   // ------------------------------------------------------------------
   function automatic logic lfsr_fb(input logic [HIST_W-1:0] hist, input int pos);
      lfsr_fb = hist[pos - TAP_NEAR] ^ hist[pos - TAP_FAR];
   endfunction

   // ------------------------------------------------------------------
   // registers and their next-state values
   // ------------------------------------------------------------------
   logic [LFSR_LEN-1:0]   state_q;
   logic [LFSR_LEN-1:0]   state_d;
   logic                  valid_q;
   logic                  valid_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;
   logic [HDR_WIDTH-1:0]  hdr_q;
   logic [HDR_WIDTH-1:0]  hdr_d;

   // ------------------------------------------------------------------
   // combinational datapath and handshake
   // ------------------------------------------------------------------
   logic [HIST_W-1:0]     hist_s;       // concatenated line history for this word
   logic [DATA_WIDTH-1:0] word_s;       // processed payload for the offered word
   logic [LFSR_LEN-1:0]   state_adv_s;  // state after absorbing the offered word
   logic                  s_ready_s;
   logic                  xfer_in_s;
   logic                  xfer_out_s;

   // Unroll the serial LFSR across the word. hist_s[LFSR_LEN-1-k] is
   // state[k], and hist_s[LFSR_LEN+i] is line bit c[i]. A tap k positions
   // back from bit i is therefore hist_s[LFSR_LEN+i-k]. This one index
   // covers both cases: a bit earlier in the same word, or a bit still
   // held in the state.
   always_comb begin
      hist_s = {HIST_W{1'b0}};
      word_s = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < LFSR_LEN; k++) begin
         hist_s[LFSR_LEN-1-k] = state_q[k];
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (DESCRAMBLE != 0) begin
            // received bit is already on the line; strip the sequence
            hist_s[LFSR_LEN+i] = bus.s_data[i];
            word_s[i]          = bus.s_data[i] ^ lfsr_fb(hist_s, LFSR_LEN + i);
         end else begin
            // scrambled bit goes to the line and back into the history
            hist_s[LFSR_LEN+i] = bus.s_data[i] ^ lfsr_fb(hist_s, LFSR_LEN + i);
            word_s[i]          = hist_s[LFSR_LEN+i];
         end
      end
   end

   // The next state is the newest 58 line bits, with the newest in state[0].
   // For narrow words this keeps part of the old state, shifted up by
   // DATA_WIDTH.
   always_comb begin
      state_adv_s = {LFSR_LEN{1'b0}};
      for (int k = 0; k < LFSR_LEN; k++) begin
         state_adv_s[k] = hist_s[HIST_W-1-k];
      end
   end

   // Handshake: a single output register, refillable in the cycle it drains.
   always_comb begin
      s_ready_s  = (~valid_q) | bus.m_ready;
      xfer_in_s  = bus.s_valid & s_ready_s;
      xfer_out_s = valid_q & bus.m_ready;
   end

   // Next-state selection for the output register and the valid flag.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      hdr_d   = hdr_q;
      if (xfer_in_s) begin
         valid_d = 1'b1;
         data_d  = word_s;
         hdr_d   = bus.s_hdr;
      end else if (xfer_out_s) begin
         valid_d = 1'b0;
      end else begin
         // idle or stalled: hold the output word stable
         valid_d = valid_q;
      end
   end

`ifdef PCS_SCR_SEED_LOAD_EN
   // LFSR state update; a reseed overrides the advance from a word taken this cycle.
   always_comb begin
      state_d = state_q;
      if (seed_load) begin
         state_d = seed_value;
      end else if (xfer_in_s) begin
         state_d = state_adv_s;
      end else begin
         state_d = state_q;
      end
   end
`else
   // LFSR state update; advances only on accepted words.
   always_comb begin
      state_d = state_q;
      if (xfer_in_s) begin
         state_d = state_adv_s;
      end else begin
         state_d = state_q;
      end
   end
`endif

   // State and output registers; reset discards any held word and reloads SEED.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
         valid_q <= 1'b0;
         data_q  <= {DATA_WIDTH{1'b0}};
         hdr_q   <= {HDR_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         hdr_q   <= hdr_d;
      end
   end

   // ------------------------------------------------------------------
   // outputs: everything except s_ready comes straight from flops
   // ------------------------------------------------------------------
   assign bus.s_ready = s_ready_s;
   assign bus.m_valid = valid_q;
   assign bus.m_data  = data_q;
   assign bus.m_hdr   = hdr_q;

endmodule

// File: tb/tb_pcs_scrambler_stream.sv
// tb_pcs_scrambler_stream: table vectors plus scoreboard checks for
// pcs_scrambler_stream. Instances:
//   a: scrambler, 64b, SEED=0      b: descrambler, 64b, SEED=0
//   c->d: scrambler (SEED ones) feeding descrambler (SEED=0), round trip
//   e: scrambler, 8b word, 1b header, SEED ones
// Reseed checks are built in when PCS_SCR_SEED_LOAD_EN is defined.

module tb_pcs_scrambler_stream;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pcs_scrambler_stream_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bus_a ();
   pcs_scrambler_stream_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bus_b ();
   pcs_scrambler_stream_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bus_c ();
   pcs_scrambler_stream_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bus_d ();
   pcs_scrambler_stream_if #(.DATA_WIDTH(8),  .HDR_WIDTH(1)) bus_e ();

   logic        seed_load_a  = 1'b0;
   logic [57:0] seed_value_a = 58'd0;
   logic        tie_lo       = 1'b0;
   logic [57:0] tie_seed     = 58'd0;

   pcs_scrambler_stream #(.DATA_WIDTH(64), .HDR_WIDTH(2), .DESCRAMBLE(0), .SEED(58'd0)) u_a (
      .CLK(clk), .rst_n(rst_n),
`ifdef PCS_SCR_SEED_LOAD_EN
      .seed_load(seed_load_a), .seed_value(seed_value_a),
`endif
      .bus(bus_a.slave));
   pcs_scrambler_stream #(.DATA_WIDTH(64), .HDR_WIDTH(2), .DESCRAMBLE(1), .SEED(58'd0)) u_b (
      .CLK(clk), .rst_n(rst_n),
`ifdef PCS_SCR_SEED_LOAD_EN
      .seed_load(tie_lo), .seed_value(tie_seed),
`endif
      .bus(bus_b.slave));
   pcs_scrambler_stream #(.DATA_WIDTH(64), .HDR_WIDTH(2), .DESCRAMBLE(0), .SEED({58{1'b1}})) u_c (
      .CLK(clk), .rst_n(rst_n),
`ifdef PCS_SCR_SEED_LOAD_EN
      .seed_load(tie_lo), .seed_value(tie_seed),
`endif
      .bus(bus_c.slave));
   pcs_scrambler_stream #(.DATA_WIDTH(64), .HDR_WIDTH(2), .DESCRAMBLE(1), .SEED(58'd0)) u_d (
      .CLK(clk), .rst_n(rst_n),
`ifdef PCS_SCR_SEED_LOAD_EN
      .seed_load(tie_lo), .seed_value(tie_seed),
`endif
      .bus(bus_d.slave));
   pcs_scrambler_stream #(.DATA_WIDTH(8), .HDR_WIDTH(1), .DESCRAMBLE(0)) u_e (
      .CLK(clk), .rst_n(rst_n),
`ifdef PCS_SCR_SEED_LOAD_EN
      .seed_load(tie_lo), .seed_value(tie_seed),
`endif
      .bus(bus_e.slave));

   // round-trip chain: scrambler c output feeds descrambler d input
   assign bus_d.s_valid = bus_c.m_valid;
   assign bus_d.s_data  = bus_c.m_data;
   assign bus_d.s_hdr   = bus_c.m_hdr;
   assign bus_c.m_ready = bus_d.s_ready;

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  h;
   } exp_t;

   typedef struct {
      logic [63:0] din;
      logic [1:0]  hdr;
      logic [63:0] exp_scr;
      logic [63:0] exp_dsc;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qd[$];
   exp_t qe[$];
   exp_t xa, xb, xd, xe;
   vec_t tbl[2];

   int          cmp_cnt = 0;
   int          fail_cnt = 0;
   int          d_seen = 0;
   logic [57:0] ms_a, ms_b, ms_e;
   bit          rand_a = 1'b0;
   bit          rand_d = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL %s: output word with empty scoreboard", name);
   endtask

   // Bit-serial reference: st[0] is the newest line bit, st[38]/st[57] are taps 39/58.
   task automatic model(input int u, input logic [63:0] d, output logic [63:0] o);
      logic [57:0] st;
      int          w;
      bit          dsc;
      logic        c;
      o = 64'd0; w = 64; dsc = 1'b0; st = 58'd0;
      case (u)
         0: st = ms_a;
         1: begin st = ms_b; dsc = 1'b1; end
         3: begin st = ms_e; w = 8; end
         default: w = 0;
      endcase
      for (int i = 0; i < w; i++) begin
         if (dsc) begin
            c = d[i];
            o[i] = c ^ st[38] ^ st[57];
         end else begin
            c = d[i] ^ st[38] ^ st[57];
            o[i] = c;
         end
         st = {st[56:0], c};
      end
      case (u)
         0: ms_a = st;
         1: ms_b = st;
         3: ms_e = st;
         default: ;
      endcase
   endtask

   task automatic drive(input int u, input logic v, input logic [63:0] d, input logic [1:0] h);
      case (u)
         0: begin bus_a.s_valid = v; bus_a.s_data = d; bus_a.s_hdr = h; end
         1: begin bus_b.s_valid = v; bus_b.s_data = d; bus_b.s_hdr = h; end
         2: begin bus_c.s_valid = v; bus_c.s_data = d; bus_c.s_hdr = h; end
         3: begin bus_e.s_valid = v; bus_e.s_data = d[7:0]; bus_e.s_hdr = h[0]; end
         default: ;
      endcase
   endtask

   function automatic logic rdy(input int u);
      case (u)
         0: rdy = bus_a.s_ready;
         1: rdy = bus_b.s_ready;
         2: rdy = bus_c.s_ready;
         3: rdy = bus_e.s_ready;
         default: rdy = 1'b0;
      endcase
   endfunction

   task automatic push(input int u, input logic [63:0] e, input logic [1:0] h);
      case (u)
         0: qa.push_back({e, h});
         1: qb.push_back({e, h});
         2: qd.push_back({e, h});
         3: qe.push_back({e, h});
         default: ;
      endcase
   endtask

   task automatic idle(input int u);
      drive(u, 1'b0, 64'd0, 2'd0);
   endtask

   // Offer a word, wait (bounded) for acceptance, and log its expected output.
   // Returns at posedge+1 with the word taken and s_valid still high.
   task automatic send(input int u, input logic [63:0] d, input logic [1:0] h, input logic [63:0] e);
      bit ok;
      ok = 1'b0;
      drive(u, 1'b1, d, h);
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (rdy(u)) begin
            push(u, e, h);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         cmp_cnt++;
         fail_cnt++;
         $display("FAIL send_timeout: unit %0d ready=0, want 1", u);
         idle(u);
      end
   endtask

   task automatic send_m(input int u, input logic [63:0] d, input logic [1:0] h);
      logic [63:0] e;
      if (u == 2) begin
         e = d;
      end else begin
         model(u, d, e);
      end
      send(u, d, h, e);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 2000 && !done; t++) begin
         @(negedge clk); #1;
         done = (qa.size() == 0) && (qb.size() == 0) && (qd.size() == 0) && (qe.size() == 0);
      end
      @(posedge clk); #1;
      check("drain_empty", 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rand_a = 1'b0;
      rand_d = 1'b0;
      seed_load_a = 1'b0;
      for (int u = 0; u < 4; u++) idle(u);
      bus_a.m_ready = 1'b1;
      bus_b.m_ready = 1'b1;
      bus_d.m_ready = 1'b1;
      bus_e.m_ready = 1'b1;
      #1;
      qa.delete(); qb.delete(); qd.delete(); qe.delete();
      ms_a = 58'd0; ms_b = 58'd0; ms_e = {58{1'b1}};
      d_seen = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Random downstream backpressure, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rand_a) bus_a.m_ready = ($urandom_range(0, 1) == 1);
      if (rand_d) bus_d.m_ready = ($urandom_range(0, 1) == 1);
   end

   // Scoreboard monitors: a transfer out is seen on the falling edge before it completes.
   always @(negedge clk) begin
      if (bus_a.m_valid && bus_a.m_ready) begin
         if (qa.size() == 0) unexpected("a_extra");
         else begin
            xa = qa.pop_front();
            check("a_data", bus_a.m_data, xa.d);
            check("a_hdr", 64'(bus_a.m_hdr), 64'(xa.h));
         end
      end
      if (bus_b.m_valid && bus_b.m_ready) begin
         if (qb.size() == 0) unexpected("b_extra");
         else begin
            xb = qb.pop_front();
            check("b_data", bus_b.m_data, xb.d);
            check("b_hdr", 64'(bus_b.m_hdr), 64'(xb.h));
         end
      end
      if (bus_d.m_valid && bus_d.m_ready) begin
         if (qd.size() == 0) unexpected("rt_extra");
         else begin
            xd = qd.pop_front();
            if (d_seen > 0) check("rt_data", bus_d.m_data, xd.d);
            check("rt_hdr", 64'(bus_d.m_hdr), 64'(xd.h));
            d_seen++;
         end
      end
      if (bus_e.m_valid && bus_e.m_ready) begin
         if (qe.size() == 0) unexpected("e_extra");
         else begin
            xe = qe.pop_front();
            check("e_data", 64'(bus_e.m_data), 64'(xe.d[7:0]));
            check("e_hdr", 64'(bus_e.m_hdr), 64'(xe.h[0]));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [63:0] e;
      logic [63:0] rnd;
      logic [1:0]  rh;

      tbl[0] = '{din: 64'h1, hdr: 2'b01, exp_scr: 64'h0400_0080_0000_0001, exp_dsc: 64'h0400_0080_0000_0001};
      tbl[1] = '{din: 64'h0, hdr: 2'b10, exp_scr: 64'h0030_0000_0000_4000, exp_dsc: 64'h0};

      rst_n = 1'b0;
      for (int u = 0; u < 4; u++) idle(u);
      bus_a.m_ready = 1'b1; bus_b.m_ready = 1'b1; bus_d.m_ready = 1'b1; bus_e.m_ready = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      // reset state
      check("rst_a_valid", 64'(bus_a.m_valid), 64'd0);
      check("rst_a_data", bus_a.m_data, 64'd0);
      check("rst_a_hdr", 64'(bus_a.m_hdr), 64'd0);
      check("rst_a_ready", 64'(bus_a.s_ready), 64'd1);
      check("rst_b_valid", 64'(bus_b.m_valid), 64'd0);
      check("rst_e_data", 64'(bus_e.m_data), 64'd0);

      // scrambler table vectors, back to back, 1-cycle latency
      for (int i = 0; i < 2; i++) begin
         model(0, tbl[i].din, e);
         send(0, tbl[i].din, tbl[i].hdr, tbl[i].exp_scr);
         check("t1_lat_valid", 64'(bus_a.m_valid), 64'd1);
         check("t1_lat_data", bus_a.m_data, tbl[i].exp_scr);
      end
      idle(0);
      // descrambler table vectors
      for (int i = 0; i < 2; i++) begin
         model(1, tbl[i].din, e);
         send(1, tbl[i].din, tbl[i].hdr, tbl[i].exp_dsc);
      end
      idle(1);
      drain();

      // descrambler and narrow-word scrambler against the serial model
      for (int n = 0; n < 20; n++) begin
         rnd = {$urandom, $urandom};
         send_m(1, rnd, 2'($urandom_range(0, 3)));
      end
      idle(1);
      for (int n = 0; n < 30; n++) begin
         rnd = {$urandom, $urandom};
         send_m(3, rnd, 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) begin
            idle(3);
            @(posedge clk); #1;
         end
      end
      idle(3);
      drain();

      // backpressure: 3 stall cycles with s_valid high
      do_reset();
      model(0, tbl[0].din, e);
      send(0, tbl[0].din, tbl[0].hdr, tbl[0].exp_scr);
      bus_a.m_ready = 1'b0;
      drive(0, 1'b1, tbl[1].din, tbl[1].hdr);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_s_ready", 64'(bus_a.s_ready), 64'd0);
         check("stall_m_valid", 64'(bus_a.m_valid), 64'd1);
         check("stall_data", bus_a.m_data, tbl[0].exp_scr);
         check("stall_hdr", 64'(bus_a.m_hdr), 64'(tbl[0].hdr));
         @(posedge clk); #1;
      end
      bus_a.m_ready = 1'b1;
      model(0, tbl[1].din, e);
      send(0, tbl[1].din, tbl[1].hdr, tbl[1].exp_scr);
      idle(0);
      drain();

      // same vectors with input gaps and random downstream ready
      do_reset();
      rand_a = 1'b1;
      for (int i = 0; i < 2; i++) begin
         model(0, tbl[i].din, e);
         send(0, tbl[i].din, tbl[i].hdr, tbl[i].exp_scr);
         idle(0);
         repeat (2) @(posedge clk);
         #1;
      end
      for (int n = 0; n < 40; n++) begin
         rnd = {$urandom, $urandom};
         send_m(0, rnd, 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 2) == 0) begin
            idle(0);
            @(posedge clk); #1;
         end
      end
      idle(0);
      drain();
      rand_a = 1'b0;
      bus_a.m_ready = 1'b1;

      // reset between words 5 and 6
      do_reset();
      for (int n = 0; n < 5; n++) begin
         rnd = {$urandom, $urandom};
         send_m(0, rnd, 2'b11);
      end
      idle(0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 64'(bus_a.m_valid), 64'd0);
      check("rst_mid_data", bus_a.m_data, 64'd0);
      do_reset();
      model(0, tbl[0].din, e);
      send(0, tbl[0].din, tbl[0].hdr, tbl[0].exp_scr);
      idle(0);
      check("rst_fresh_data", bus_a.m_data, tbl[0].exp_scr);
      drain();

      // round trip with random words, headers and backpressure
      do_reset();
      rand_d = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         rnd = {$urandom, $urandom};
         rh = 2'($urandom_range(0, 3));
         send(2, rnd, rh, rnd);
         if ($urandom_range(0, 7) == 0) begin
            idle(2);
            @(posedge clk); #1;
         end
      end
      idle(2);
      drain();
      rand_d = 1'b0;
      bus_d.m_ready = 1'b1;
      check("rt_count", 64'(d_seen), 64'd1000);

`ifdef PCS_SCR_SEED_LOAD_EN
      // reseed concurrent with an accepted word
      do_reset();
      for (int n = 0; n < 3; n++) begin
         rnd = {$urandom, $urandom};
         send_m(0, rnd, 2'b11);
      end
      rnd = {$urandom, $urandom};
      model(0, rnd, e);
      seed_value_a = 58'd0;
      seed_load_a = 1'b1;
      send(0, rnd, 2'b01, e);
      seed_load_a = 1'b0;
      check("seed_old_state_word", bus_a.m_data, e);
      ms_a = 58'd0;
      model(0, 64'h1, e);
      send(0, 64'h1, 2'b10, 64'h0400_0080_0000_0001);
      idle(0);
      check("seed_new_state_word", bus_a.m_data, 64'h0400_0080_0000_0001);
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/pcs_scrambler_stream.md
Name: pcs_scrambler_stream

Overview:
Parametrised, streaming self-synchronous scrambler/descrambler for g(x) = x^58 + x^39 + 1, used in the 40G/100G PCS transmit and receive paths.
- Generalises the 64-bit descrambler to any word width and either direction (compile-time mode).
- Adds a header sideband passed through unscrambled, valid/ready flow control and a registered output stage.
- Sits between the 64b/66b encoder and the gearbox on TX, and between the block-lock/gearbox and the decoder on RX.

Parameters:
DATA_WIDTH, 64, payload bits per word; legal range 1..512.
HDR_WIDTH, 2, sideband header bits carried alongside each word, never scrambled; legal range 1..8.
DESCRAMBLE, 0, 0 = scrambler (feedback), 1 = descrambler (feed-forward).
SEED, 58'h3FF_FFFF_FFFF_FFFF, LFSR state loaded at reset.

Ports:
CLK  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input word valid
s_ready  output  1  block can accept input word
s_data  input  DATA_WIDTH  payload, bit 0 transmitted first
s_hdr  input  HDR_WIDTH  header sideband
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts output word
m_data  output  DATA_WIDTH  scrambled/descrambled payload
m_hdr  output  HDR_WIDTH  header, delayed copy of s_hdr

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous deassert by the integrator): state <= SEED, m_valid = 0, m_data = 0, m_hdr = 0. Reset mid-stream discards the held word, and the next accepted word uses SEED.
- History model: state[k] = line (scrambled) bit transmitted k+1 bits before the current bit; state[0] is the most recent. In both modes the state holds scrambled-stream bits.
- Per word, bit i from 0 to DATA_WIDTH-1:
  - Line bit c[i] is the scrambled bit: c[i] = p[i] ^ h(39) ^ h(58) in scramble mode; c[i] = s_data[i] in descramble mode.
  - h(k) = c[i-k] if i >= k, else state[k-i-1].
  - Scramble mode: p = s_data, and m_data[i] = c[i].
  - Descramble mode: m_data[i] = c[i] ^ h(39) ^ h(58).
- Next state: the last 58 bits of the concatenated history, newest in state[0]. If DATA_WIDTH < 58, older bits shift up by DATA_WIDTH.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational).
  - Transfer in occurs when s_valid && s_ready; transfer out occurs when m_valid && m_ready.
  - On transfer in: m_data, m_hdr and state update at the next edge, and m_valid <= 1.
  - On transfer out with no transfer in: m_valid <= 0.
  - Latency 1 cycle; full throughput (1 word/cycle) when m_ready is held high.
- Stall: while m_valid && !m_ready, m_data and m_hdr are held stable and state does not advance.
- Idle: when s_valid is low, state does not advance. State advances only on accepted words, never per cycle.
- m_hdr = s_hdr of the same accepted word, unmodified, and never enters the LFSR.
- No combinational path from s_data to m_data; s_valid does not depend on s_ready.

Optional Feature:
Macro PCS_SCR_SEED_LOAD_EN.
- Defined: adds ports seed_load (input, 1) and seed_value (input, 58).
  - When seed_load is high at an edge, state <= seed_value, overriding the update from any transfer in during that cycle.
  - A word accepted in that same cycle is still processed with the old state; only the following word uses seed_value.
  - m_valid, m_data and m_hdr are unaffected by the load.
- Not defined: the ports do not exist, and state changes only by reset or accepted words.

Test Plan:
1. Scrambler, SEED=0, DATA_WIDTH=64, m_ready=1: send s_data 64'h1 then 64'h0 -> m_data = 64'h0400_0080_0000_0001, then 64'h0030_0000_0000_4000, each 1 cycle after acceptance.
2. Descrambler, SEED=0: send 64'h1 then 64'h0 -> m_data = 64'h0400_0080_0000_0001, then 64'h0.
3. Round trip: scrambler (SEED=all ones) feeding descrambler (SEED=0) with 1000 random words and random s_hdr -> after the first word, descrambler m_data equals the original payload; m_hdr always matches.
4. Backpressure: m_ready low for 3 cycles with s_valid high -> s_ready=0, m_data/m_hdr held, and the output sequence equals the no-stall run from test 1. Repeat with s_valid gaps -> identical outputs.
5. Reset mid-stream: assert rst_n low between words 5 and 6 -> m_valid=0 within the reset cycle; after release, the first word out equals the first word of a fresh run.
6. With PCS_SCR_SEED_LOAD_EN, scrambler: load seed_value=0 concurrent with accepting word A, then send 64'h1 -> A uses the old state; the next output = 64'h0400_0080_0000_0001.
